lector_display_7seg: RTL and testbench

- Monitors the multiplexed anode/segment lines driven by the team's 4-digit 7-segment display controller and reconstructs the four displayed hex digits.
- It is the receiving end of the display interface.
- Used for loopback self-check on the board and as a scoreboard front-end in benches, sitting directly on the anode/segment nets.

---
 rtl/lector_display_7seg_pkg.sv | 29 ++
 rtl/lector_display_7seg_decodificador_7seg.sv | 35 +++
 rtl/lector_display_7seg.sv | 176 +++++++++++++++++
 tb/tb_lector_display_7seg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lector_display_7seg_pkg.sv
// Shared definitions for the 7-segment display interface: active-low segment
// patterns for the 16 hex glyphs and the capture FSM state encoding.
package lector_display_7seg_pkg;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] Seg0 = 7'b1000000;
    localparam logic [6:0] Seg1 = 7'b1111001;
    localparam logic [6:0] Seg2 = 7'b0100100;
    localparam logic [6:0] Seg3 = 7'b0110000;
    localparam logic [6:0] Seg4 = 7'b0011001;
    localparam logic [6:0] Seg5 = 7'b0010010;
    localparam logic [6:0] Seg6 = 7'b0000010;
    localparam logic [6:0] Seg7 = 7'b1111000;
    localparam logic [6:0] Seg8 = 7'b0000000;
    localparam logic [6:0] Seg9 = 7'b0010000;
    localparam logic [6:0] SegA = 7'b0001000;
    localparam logic [6:0] SegB = 7'b0000011;
    localparam logic [6:0] SegC = 7'b1000110;
    localparam logic [6:0] SegD = 7'b0100001;
    localparam logic [6:0] SegE = 7'b0000110;
    localparam logic [6:0] SegF = 7'b0001110;

    typedef enum logic [1:0] {
        StEspera    = 2'd0,
        StContando  = 2'd1,
        StCapturado = 2'd2
    } estado_e;

endpackage

// File: rtl/lector_display_7seg_decodificador_7seg.sv
// Combinational decode of active-low segment lines into a hex nibble; any
// pattern outside the 16 glyphs is flagged as not legal.
module decodificador_7seg
    import lector_display_7seg_pkg::*;
(
    input  logic [6:0] segmentos,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (segmentos)
            Seg0:    nibble = 4'h0;
            Seg1:    nibble = 4'h1;
            Seg2:    nibble = 4'h2;
            Seg3:    nibble = 4'h3;
            Seg4:    nibble = 4'h4;
            Seg5:    nibble = 4'h5;
            Seg6:    nibble = 4'h6;
            Seg7:    nibble = 4'h7;
            Seg8:    nibble = 4'h8;
            Seg9:    nibble = 4'h9;
            SegA:    nibble = 4'hA;
            SegB:    nibble = 4'hB;
            SegC:    nibble = 4'hC;
            SegD:    nibble = 4'hD;
            SegE:    nibble = 4'hE;
            SegF:    nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/lector_display_7seg.sv
// Receiver for the multiplexed 4-digit 7-segment bus: synchronizes the pins,
// waits for a stable pattern and latches the decoded digit per anode.
module lector_display_7seg
    import lector_display_7seg_pkg::*;
#(
    parameter int unsigned N_ESTABLE = 4,
    parameter int unsigned T_TIMEOUT = 1000000,
    parameter int unsigned W_TIMEOUT = 20
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Anodos,
    input  logic [6:0] i_Segmentos,
    output logic [3:0] o_Datos1,
    output logic [3:0] o_Datos2,
    output logic [3:0] o_Datos3,
    output logic [3:0] o_Datos4,
    output logic [3:0] o_Valido,
    output logic       o_Completo,
    output logic       o_Actualizado,
    output logic       o_Error
);

    localparam int unsigned W_CNT = $clog2(N_ESTABLE + 1);
    localparam logic [W_CNT-1:0]     CntIni = W_CNT'(2);
    localparam logic [W_CNT-1:0]     CntMax = W_CNT'(N_ESTABLE);
    localparam logic [W_TIMEOUT-1:0] TmoMax = W_TIMEOUT'(T_TIMEOUT);

    logic [10:0]          sync_q, muestra_q, previa_q;
    logic [3:0]           anodos;
    logic [6:0]           segmentos;
    logic                 cambio, anodo_legal, anodo_blanco;
    logic [1:0]           sel;
    logic                 seg_legal;
    logic [3:0]           nibble;
    estado_e              estado_q, estado_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;
    logic                 evaluar, capturar, error_ev;
    logic [W_TIMEOUT-1:0] tmo_q, tmo_d;
    logic [3:0][3:0]      datos_q, datos_d;
    logic [3:0]           valido_q, valido_d;
    logic                 completo_q, act_q, err_q;

    assign {anodos, segmentos} = muestra_q;
    assign cambio              = (muestra_q != previa_q);
    assign anodo_blanco        = (anodos == 4'b1111);

    always_comb begin
        anodo_legal = 1'b1;
        sel         = 2'd0;
        case (anodos)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: anodo_legal = 1'b0;
        endcase
    end

    decodificador_7seg u_decodificador (
        .segmentos (segmentos),
        .legal     (seg_legal),
        .nibble    (nibble)
    );

    // Two-flop synchronizer plus a one-sample history for change detection
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            sync_q    <= '1;
            muestra_q <= '1;
            previa_q  <= '1;
        end else begin
            sync_q    <= {i_Anodos, i_Segmentos};
            muestra_q <= sync_q;
            previa_q  <= muestra_q;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            estado_q <= StEspera;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        unique case (estado_q)
            StEspera: begin
                if (!cambio && !anodo_blanco) begin
                    estado_d = StContando;
                    cnt_d    = CntIni;
                end
            end
            StContando: begin
                if (cambio) begin
                    estado_d = StEspera;
                    cnt_d    = '0;
                end else if (cnt_q == CntMax) begin
                    estado_d = StCapturado;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapturado: begin
                if (cambio) begin
                    estado_d = StEspera;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = StEspera;
                cnt_d    = '0;
            end
        endcase
    end

    // Blank anodes never leave StEspera, so anything evaluated but not
    // captured is an illegal anode or segment pattern.
    always_comb begin
        evaluar  = (estado_q == StContando) && !cambio && (cnt_q == CntMax);
        capturar = evaluar && anodo_legal && seg_legal;
        error_ev = evaluar && !capturar;
    end

    always_comb begin
        datos_d  = datos_q;
        valido_d = valido_q;
        if (capturar) begin
            tmo_d = '0;
        end else if (tmo_q == TmoMax) begin
            tmo_d = TmoMax;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        if (tmo_d == TmoMax) begin
            valido_d = '0;
        end
        if (capturar) begin
            datos_d[sel]  = nibble;
            valido_d[sel] = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            tmo_q      <= '0;
            datos_q    <= '0;
            valido_q   <= '0;
            completo_q <= 1'b0;
            act_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            datos_q    <= datos_d;
            valido_q   <= valido_d;
            completo_q <= &valido_d;
            act_q      <= capturar;
            err_q      <= error_ev;
        end
    end

    assign o_Datos1      = datos_q[0];
    assign o_Datos2      = datos_q[1];
    assign o_Datos3      = datos_q[2];
    assign o_Datos4      = datos_q[3];
    assign o_Valido      = valido_q;
    assign o_Completo    = completo_q;
    assign o_Actualizado = act_q;
    assign o_Error       = err_q;

endmodule

// File: tb/tb_lector_display_7seg.sv
// Directed bench for lector_display_7seg: scan capture, timeout, glitch
// rejection, illegal patterns and asynchronous mid-capture reset.
module tb_lector_display_7seg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] anodos = 4'b1111;
    logic [6:0] segmentos = 7'b1111111;
    logic [3:0] datos1, datos2, datos3, datos4, valido;
    logic       completo, act, err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int act_cnt = 0;
    int err_cnt = 0;
    int last_act = -1;
    int start = 0;
    int a0, e0, guard;

    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    logic [3:0] dig_tab [4];

    lector_display_7seg #(
        .N_ESTABLE (4),
        .T_TIMEOUT (50),
        .W_TIMEOUT (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst_n),
        .i_Anodos      (anodos),
        .i_Segmentos   (segmentos),
        .o_Datos1      (datos1),
        .o_Datos2      (datos2),
        .o_Datos3      (datos3),
        .o_Datos4      (datos4),
        .o_Valido      (valido),
        .o_Completo    (completo),
        .o_Actualizado (act),
        .o_Error       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (act === 1'b1) begin
            act_cnt++;
            last_act = cyc;
        end
        if (err === 1'b1) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        anodos    = an;
        segmentos = seg;
        start     = cyc + 1;
        tick(n);
    endtask

    initial begin
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0010000, 7'b1111000, 7'b0010010, 7'b1111001};
        dig_tab = '{4'h9, 4'h7, 4'h5, 4'h1};

        // Reset held with random pins
        repeat (20) begin
            anodos    = 4'($urandom);
            segmentos = 7'($urandom);
            @(posedge clk);
            #1;
        end
        check_eq("rst_datos1", datos1, 0);
        check_eq("rst_datos2", datos2, 0);
        check_eq("rst_datos3", datos3, 0);
        check_eq("rst_datos4", datos4, 0);
        check_eq("rst_valido", valido, 0);
        check_eq("rst_completo", completo, 0);
        check_eq("rst_act", act, 0);
        check_eq("rst_err", err, 0);

        anodos    = 4'b1111;
        segmentos = 7'b1111111;
        rst_n     = 1'b1;
        tick(3);

        // Scan 9,7,5,1 across the four digits
        a0 = act_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 4; k++) begin
            drive(an_tab[k], seg_tab[k], 8);
            check_eq($sformatf("scan_lat%0d", k), last_act, start + 6);
        end
        check_eq("scan_datos1", datos1, 4'h9);
        check_eq("scan_datos2", datos2, 4'h7);
        check_eq("scan_datos3", datos3, 4'h5);
        check_eq("scan_datos4", datos4, 4'h1);
        check_eq("scan_valido", valido, 4'b1111);
        check_eq("scan_completo", completo, 1);
        check_eq("scan_acts", act_cnt - a0, 4);
        check_eq("scan_errs", err_cnt - e0, 0);

        // Timeout: valid drops exactly 50 cycles after the last capture
        anodos    = 4'b1111;
        segmentos = 7'b1111111;
        guard     = 0;
        while (cyc < last_act + 49 && guard < 200) begin
            tick(1);
            guard++;
        end
        check_eq("tmo_guard", guard < 200, 1);
        check_eq("tmo_valido_pre", valido, 4'b1111);
        check_eq("tmo_completo_pre", completo, 1);
        tick(1);
        check_eq("tmo_valido", valido, 4'b0000);
        check_eq("tmo_completo", completo, 0);
        tick(9);
        check_eq("tmo_valido_hold", valido, 4'b0000);
        check_eq("tmo_datos1", datos1, 4'h9);
        check_eq("tmo_datos2", datos2, 4'h7);
        check_eq("tmo_datos3", datos3, 4'h5);
        check_eq("tmo_datos4", datos4, 4'h1);

        // Glitch: 3-sample 9 is ignored, stable 1 is captured once
        a0 = act_cnt;
        drive(4'b1110, 7'b0010000, 3);
        drive(4'b1110, 7'b1111001, 10);
        check_eq("glitch_datos1", datos1, 4'h1);
        check_eq("glitch_acts", act_cnt - a0, 1);
        check_eq("glitch_lat", last_act, start + 6);
        check_eq("glitch_valido", valido, 4'b0001);

        // Illegal anodes: one error, nothing captured
        a0 = act_cnt;
        e0 = err_cnt;
        drive(4'b1100, 7'b1111001, 10);
        check_eq("ill_an_errs", err_cnt - e0, 1);
        check_eq("ill_an_acts", act_cnt - a0, 0);
        check_eq("ill_an_datos1", datos1, 4'h1);

        // Illegal segments: one error, valid bit untouched
        e0 = err_cnt;
        drive(4'b1110, 7'b1010101, 10);
        check_eq("ill_seg_errs", err_cnt - e0, 1);
        check_eq("ill_seg_acts", act_cnt - a0, 0);
        check_eq("ill_seg_valido", valido, 4'b0001);
        check_eq("ill_seg_datos1", datos1, 4'h1);

        // Reset while counting clears outputs without a clock edge
        drive(4'b1101, 7'b0110000, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_datos1", datos1, 0);
        check_eq("mid_rst_datos2", datos2, 0);
        check_eq("mid_rst_valido", valido, 0);
        check_eq("mid_rst_completo", completo, 0);
        tick(2);
        a0    = act_cnt;
        rst_n = 1'b1;
        start = cyc + 1;
        tick(8);
        check_eq("mid_rst_lat", last_act, start + 6);
        check_eq("mid_rst_acts", act_cnt - a0, 1);
        check_eq("mid_rst_cap", datos2, 4'h3);
        check_eq("mid_rst_valido2", valido, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
